// File: rtl/key_conditioner.sv
// Key front end: per-key 2-FF synchroniser, counter debounce and press/release
// pulses, plus a first-press arbiter between the two player keys.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int P1_IDX          = 0,
  parameter int P2_IDX          = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic              arm,
  input  logic              disarm,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              armed,
  output logic              winner_valid,
  output logic [1:0]        winner_id
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    DECIDED = 2'b10
  } arb_state_t;

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] pressed_p1;
  logic [CNT_W-1:0]  cnt_p2 [N_KEYS];

  arb_state_t state, state_nxt;
  logic [1:0] winner_nxt;

  // Stage p0/p1: two-flop synchroniser, idles at 1 (released)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_p1 = ~sync_p1;

  // Stage p2: debounce counter; a level is accepted only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        key_press[i]   <= 1'b0;
        key_release[i] <= 1'b0;
        if (pressed_p1[i] == key_level[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          cnt_p2[i]      <= '0;
          key_level[i]   <= pressed_p1[i];
          key_press[i]   <= pressed_p1[i];
          key_release[i] <= ~pressed_p1[i];
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Arbiter: decides on the registered press pulses, so outputs trail by one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      winner_id <= 2'b00;
    end else begin
      state     <= state_nxt;
      winner_id <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner_id;
    case (state)
      IDLE: begin
        if (!disarm && arm) begin
          state_nxt  = ARMED;
          winner_nxt = 2'b00;
        end
      end
      ARMED: begin
        if (disarm) begin
          state_nxt  = IDLE;
          winner_nxt = 2'b00;
        end else if (key_press[P1_IDX] || key_press[P2_IDX]) begin
          state_nxt  = DECIDED;
          winner_nxt = {key_press[P2_IDX], key_press[P1_IDX]};
        end
      end
      DECIDED: begin
        if (disarm) begin
          state_nxt  = IDLE;
          winner_nxt = 2'b00;
        end else if (arm) begin
          state_nxt  = ARMED;
          winner_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt  = IDLE;
        winner_nxt = 2'b00;
      end
    endcase
  end

  assign armed        = (state == ARMED);
  assign winner_valid = (state == DECIDED);

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner (DEBOUNCE_CYCLES = 4): window-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_key_conditioner;
  localparam int N = 4;
  localparam int D = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] key_n;
  logic         arm;
  logic         disarm;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         armed;
  logic         winner_valid;
  logic [1:0]   winner_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .P1_IDX(0), .P2_IDX(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .arm(arm), .disarm(disarm),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .armed(armed), .winner_valid(winner_valid), .winner_id(winner_id)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw keys take two cycles to become visible; a key's level
  // flips once the last D visible samples all agree and differ from it.
  logic [N-1:0] m_p0, m_p1, m_level, m_press, m_rel, s_now;
  logic [N-1:0] sq[$];
  logic         m_armed, m_valid;
  logic [1:0]   m_win;
  bit           uniform;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_p0 = '1; m_p1 = '1;
      sq.delete();
      m_level = '0; m_press = '0; m_rel = '0;
      m_armed = 0; m_valid = 0; m_win = 2'b00;
    end else begin
      if (disarm) begin
        m_armed = 0; m_valid = 0; m_win = 2'b00;
      end else if (m_armed && (m_press[0] || m_press[3])) begin
        m_armed = 0; m_valid = 1; m_win = {m_press[3], m_press[0]};
      end else if (arm) begin
        m_armed = 1; m_valid = 0; m_win = 2'b00;
      end
      s_now = ~m_p1;
      sq.push_back(s_now);
      if (sq.size() > D) void'(sq.pop_front());
      m_press = '0; m_rel = '0;
      if (sq.size() == D) begin
        for (int i = 0; i < N; i++) begin
          uniform = 1;
          for (int j = 0; j < D; j++) if (sq[j][i] != s_now[i]) uniform = 0;
          if (uniform && s_now[i] != m_level[i]) begin
            m_level[i] = s_now[i];
            m_press[i] = s_now[i];
            m_rel[i]   = ~s_now[i];
          end
        end
      end
      m_p1 = m_p0;
      m_p0 = key_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model key_level",    32'(key_level),    32'(m_level));
      chk("model key_press",    32'(key_press),    32'(m_press));
      chk("model key_release",  32'(key_release),  32'(m_rel));
      chk("model armed",        32'(armed),        32'(m_armed));
      chk("model winner_valid", 32'(winner_valid), 32'(m_valid));
      chk("model winner_id",    32'(winner_id),    32'(m_win));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ctl(input bit a, input bit d);
    arm = a; disarm = d;
    @(negedge clk);
    arm = 0; disarm = 0;
  endtask

  int pulses;

  initial begin
    reset_n = 0; key_n = '1; arm = 0; disarm = 0;
    @(posedge clk);
    chk_en = 1;
    cyc(2);
    reset_n = 1;

    // 1: idle after reset
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pulses += $countones(key_press) + $countones(key_release);
    end
    chk("t1 pulses", 32'(pulses), 0);
    chk("t1 key_level", 32'(key_level), 0);
    chk("t1 winner_id", 32'(winner_id), 0);
    chk("t1 armed", 32'(armed), 0);

    // 2: clean press and release of key 0
    key_n[0] = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("t2 press early", 32'(key_press[0]), 0);
      if (k == 6) chk("t2 press", 32'(key_press[0]), 1);
      if (k == 7) begin
        chk("t2 press single", 32'(key_press[0]), 0);
        chk("t2 level", 32'(key_level[0]), 1);
      end
    end
    key_n[0] = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("t2 release early", 32'(key_release[0]), 0);
      if (k == 6) chk("t2 release", 32'(key_release[0]), 1);
      if (k == 7) chk("t2 level low", 32'(key_level[0]), 0);
    end

    // 3: bouncing key 3 then settling low
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      key_n[3] = (t % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        pulses += $countones(key_press) + $countones(key_release);
      end
    end
    chk("t3 bounce pulses", 32'(pulses), 0);
    key_n[3] = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      pulses += key_press[3];
      if (k == 6) chk("t3 press", 32'(key_press[3]), 1);
    end
    chk("t3 press count", 32'(pulses), 1);
    key_n = '1;
    cyc(8);

    // 4: P2 wins, later P1 press ignored
    pulse_ctl(1, 0);
    chk("t4 armed", 32'(armed), 1);
    key_n[3] = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) chk("t4 armed at press", 32'({key_press[3], armed}), 32'b11);
      if (k == 7) chk("t4 decision", 32'({armed, winner_valid, winner_id}), 32'b0110);
    end
    key_n[0] = 0;
    cyc(8);
    chk("t4 id held", 32'({winner_valid, winner_id}), 32'b110);
    key_n = '1;
    cyc(8);

    // 5: tie, re-arm, disarm, arm+disarm together
    pulse_ctl(1, 0);
    key_n = 4'b0110;
    cyc(7);
    chk("t5 tie", 32'({winner_valid, winner_id}), 32'b111);
    pulse_ctl(1, 0);
    chk("t5 rearm", 32'({armed, winner_valid, winner_id}), 32'b1000);
    pulse_ctl(0, 1);
    chk("t5 disarm", 32'({armed, winner_valid, winner_id}), 32'b0000);
    pulse_ctl(1, 1);
    chk("t5 arm+disarm", 32'(armed), 0);
    key_n = '1;
    cyc(8);

    // 6: reset mid-race with key 0 held
    key_n[0] = 0;
    cyc(8);
    pulse_ctl(1, 0);
    chk("t6 armed", 32'(armed), 1);
    cyc(2);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk("t6 reset outs",
        32'({key_level, key_press, key_release, armed, winner_valid, winner_id}), 0);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      pulses += key_press[0];
      if (k == 5) chk("t6 level early", 32'(key_level[0]), 0);
      if (k == 6) chk("t6 press", 32'({key_level[0], key_press[0]}), 32'b11);
    end
    chk("t6 press count", 32'(pulses), 1);
    chk("t6 no winner", 32'({armed, winner_valid, winner_id}), 0);
    key_n = '1;
    cyc(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the four raw active-low push buttons before they reach the game controller.
- Per key: 2-FF synchroniser, then counter-based debounce, then press/release edge pulses.
- Also contains a first-press arbiter for the two player keys. The controller consumes clean one-cycle presses and an unambiguous winner/tie decision, not raw KEY levels.
- Sits between the KEY pins and the game FSM, directly upstream of it.

Parameters:
- N_KEYS, 4, number of keys conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz). Minimum 2.
- P1_IDX, 0, key index treated as player 1.
- P2_IDX, 3, key index treated as player 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset, synchronous, active-low.
- key_n  in  N_KEYS  raw buttons, active-low, asynchronous to clk.
- arm  in  1  one-cycle pulse: clear any decision and start a new first-press race.
- disarm  in  1  one-cycle pulse: abandon the race and return to idle.
- key_level  out  N_KEYS  debounced level, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse when a debounced press is accepted.
- key_release  out  N_KEYS  one-cycle pulse when a debounced release is accepted.
- armed  out  1  high while the arbiter is waiting for a first press.
- winner_valid  out  1  high from the decision cycle until the next arm, disarm or reset.
- winner_id  out  2  01 = P1 first, 10 = P2 first, 11 = same-cycle tie, 00 = no decision.

Behaviour:
- Reset: one-time synchronous, when reset_n is low at a clk edge.
  - Synchroniser flops load 1 (released).
  - Debounce counters load 0.
  - key_level, key_press, key_release, armed, winner_valid and winner_id all load 0.
  - Arbiter goes to IDLE.
  - Reset mid-debounce or mid-race discards all progress. No pulse is emitted on the reset cycle.
- Synchroniser: two flops per key. Inverted output s[i] = ~sync2[i] is 1 when pressed.
- Debounce, per key:
  - The counter increments each cycle that s[i] != key_level[i], and clears to 0 on any cycle that s[i] == key_level[i]. This absorbs bounce.
  - When the counter equals DEBOUNCE_CYCLES-1 and s[i] still differs, the following happens on the next edge:
    - key_level[i] <= s[i].
    - Counter <= 0.
    - key_press[i] pulses high for exactly one cycle if the new level is 1; key_release[i] does the same if the new level is 0.
  - Latency from a clean raw edge to key_level change and pulse: DEBOUNCE_CYCLES + 2 cycles (2 synchroniser cycles + DEBOUNCE_CYCLES).
  - Counter width is clog2(DEBOUNCE_CYCLES). The counter never wraps.
- Arbiter FSM, states IDLE, ARMED and DECIDED:
  - IDLE: armed = 0, winner_valid = 0. arm goes to ARMED.
  - ARMED: armed = 1. Only key_press[P1_IDX] / key_press[P2_IDX] count. A key already held when arm arrives does not count until it is released and pressed again.
    - P1 pulse only: DECIDED, winner_id = 01.
    - P2 pulse only: DECIDED, winner_id = 10.
    - Both in the same cycle: DECIDED, winner_id = 11.
    - disarm: IDLE, winner_id = 00.
  - DECIDED: winner_valid = 1, armed = 0. winner_id holds, and later presses are ignored.
    - arm: ARMED and winner_id <= 00.
    - disarm: IDLE and winner_id <= 00.
  - arm and disarm in the same cycle: disarm wins.
  - arm while already ARMED: stay ARMED. A press pulse in that same cycle is still decided.
  - Arbiter outputs update on the clk edge after the deciding key_press pulse (1-cycle latency).
- key_level, key_press and key_release operate regardless of arbiter state.

Test Plan:
Benches run with DEBOUNCE_CYCLES = 4.
1. Reset, then hold key_n = 4'b1111 for 20 cycles -> key_level = 0, no key_press/key_release pulses, winner_id = 00, armed = 0.
2. Drop key_n[0] low cleanly and hold -> key_level[0] rises and key_press[0] is a single-cycle pulse exactly 6 cycles after the drop; raising it again gives key_release[0] 6 cycles later.
3. Toggle key_n[3] low/high every 2 cycles for 20 cycles, then hold low -> no pulse during bouncing; exactly one key_press[3] 6 cycles after the final low.
4. Pulse arm, then press key 3, then key 0 ten cycles later -> armed = 1 until the key_press[3] pulse; one cycle after it winner_valid = 1 and winner_id = 10; the key 0 press leaves winner_id = 10.
5. arm, then drop key_n[0] and key_n[3] on the same cycle -> winner_id = 11 and winner_valid = 1. A following arm clears to 00/armed; disarm then returns to IDLE with armed = 0.
6. Hold key 0 pressed, pulse arm, assert reset_n low for 1 cycle mid-race -> all outputs 0, arbiter in IDLE. After release, key_level[0] re-asserts 6 cycles after reset deassertion with one key_press[0], and no winner is decided.
